// File: rtl/guarded_mod_counter_pkg.sv
// Shared helpers for residue-guarded datapath blocks.
// res_f() returns x mod (2^g-1) by summing g-bit digits.
package guarded_mod_counter_pkg;

  localparam int unsigned RES_MAX_W = 64;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_LOAD,
    OP_UP,
    OP_DOWN
  } cnt_op_e;

  function automatic int unsigned mod_m(
    input int unsigned g
  );
    return (32'd1 << g) - 32'd1;
  endfunction

  // Bit i lands in digit position i mod g, so the sum is the digit sum.
  function automatic int unsigned res_f(
    input logic [RES_MAX_W-1:0] x,
    input int unsigned          g
  );
    int unsigned sum;
    sum = 0;
    for (int unsigned i = 0; i < RES_MAX_W; i++) begin
      if (x[i]) begin
        sum = sum + (32'd1 << (i % g));
      end
    end
    return sum % mod_m(g);
  endfunction

endpackage

// File: rtl/guarded_mod_counter_residue_calc.sv
// Combinational residue of a WIDTH-bit value modulo 2^GUARD_BITS-1.
// WIDTH must not exceed RES_MAX_W.
module residue_calc
  import guarded_mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned GUARD_BITS = 3
) (
  input  logic [WIDTH-1:0]      x,
  output logic [GUARD_BITS-1:0] r
);

  logic [RES_MAX_W-1:0] x_ext;

  always_comb begin
    x_ext = '0;
    x_ext[WIDTH-1:0] = x;
  end

  assign r = GUARD_BITS'(res_f(x_ext, GUARD_BITS));

endmodule

// File: rtl/guarded_mod_counter.sv
// Up/down modulo counter with a predicted residue guard,
// a sticky mismatch flag and a saturating error counter.
module guarded_mod_counter
  import guarded_mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned GUARD_BITS = 3,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      limit,
  input  logic                  err_clr,
  input  logic                  fault_inj,
  output logic [WIDTH-1:0]      count,
  output logic                  wrap,
  output logic [GUARD_BITS-1:0] residue,
  output logic                  err,
  output logic [ERR_CNT_W-1:0]  err_cnt
);

  localparam logic [GUARD_BITS-1:0] RES_TOP =
    GUARD_BITS'(mod_m(GUARD_BITS) - 32'd1);

  logic [WIDTH-1:0]      count_q, count_d;
  logic [GUARD_BITS-1:0] res_q, res_d;
  logic                  wrap_q, wrap_d;
  logic                  err_q, err_d;
  logic [ERR_CNT_W-1:0]  cnt_q, cnt_d;

  logic [GUARD_BITS-1:0] res_count;
  logic [GUARD_BITS-1:0] res_load;
  logic [GUARD_BITS-1:0] res_limit;
  logic                  mismatch;
  cnt_op_e               op;

  residue_calc #(
    .WIDTH(WIDTH), .GUARD_BITS(GUARD_BITS)
  ) u_res_count (
    .x(count_q), .r(res_count)
  );

  residue_calc #(
    .WIDTH(WIDTH), .GUARD_BITS(GUARD_BITS)
  ) u_res_load (
    .x(load_val), .r(res_load)
  );

  residue_calc #(
    .WIDTH(WIDTH), .GUARD_BITS(GUARD_BITS)
  ) u_res_limit (
    .x(limit), .r(res_limit)
  );

  assign mismatch = (res_count != res_q);

  always_comb begin
    op = OP_HOLD;
    if (load) begin
      op = OP_LOAD;
    end else if (en) begin
      op = up ? OP_UP : OP_DOWN;
    end
  end

  always_comb begin
    count_d = count_q;
    res_d   = res_q;
    wrap_d  = 1'b0;
    unique case (op)
      OP_LOAD: begin
        count_d = load_val;
        res_d   = res_load;
      end
      OP_UP: begin
        if (count_q >= limit) begin
          count_d = '0;
          res_d   = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
          res_d   = (res_q == RES_TOP) ? '0 : res_q + 1'b1;
        end
      end
      OP_DOWN: begin
        if (count_q == '0) begin
          count_d = limit;
          res_d   = res_limit;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
          res_d   = (res_q == '0) ? RES_TOP : res_q - 1'b1;
        end
      end
      default: begin
      end
    endcase
    // Corrupt only the count so the guard sees a mismatch.
    if (fault_inj) begin
      count_d[0] = ~count_d[0];
    end
  end

  always_comb begin
    err_d = err_q;
    cnt_d = cnt_q;
    if (mismatch) begin
      err_d = 1'b1;
      if (err_clr) begin
        cnt_d = ERR_CNT_W'(1);
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (err_clr) begin
      err_d = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      res_q   <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      count_q <= count_d;
      res_q   <= res_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign count   = count_q;
  assign wrap    = wrap_q;
  assign residue = res_q;
  assign err     = err_q;
  assign err_cnt = cnt_q;

endmodule

// File: tb/tb_guarded_mod_counter.sv
// Scoreboard bench for guarded_mod_counter (WIDTH=8, M=7).
// Directed spec scenarios followed by randomized traffic.
module tb_guarded_mod_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] limit;
  logic       err_clr;
  logic       fault_inj;
  logic [7:0] count;
  logic       wrap;
  logic [2:0] residue;
  logic       err;
  logic [7:0] err_cnt;

  guarded_mod_counter #(
    .WIDTH(8), .GUARD_BITS(3), .ERR_CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .up(up),
    .load(load), .load_val(load_val), .limit(limit),
    .err_clr(err_clr), .fault_inj(fault_inj),
    .count(count), .wrap(wrap), .residue(residue),
    .err(err), .err_cnt(err_cnt)
  );

  typedef struct {
    int count;
    int wrap;
    int res;
    int err;
    int cnt;
    int id;
  } exp_t;

  exp_t q[$];
  int   n_chk;
  int   n_fail;
  int   n_cyc;

  // Model state: abstract integers, residue as plain mod-7 arithmetic.
  int m_count, m_res, m_err, m_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int id,
                     input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d expected %0d",
               name, id, act, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit u,
                     input bit ld, input int lv, input int lim,
                     input bit clr, input bit f);
    exp_t x;
    bit   mis;
    int   w;
    @(negedge clk);
    rst = r; en = e; up = u; load = ld;
    load_val = 8'(lv); limit = 8'(lim);
    err_clr = clr; fault_inj = f;
    w = 0;
    if (r) begin
      m_count = 0; m_res = 0; m_err = 0; m_cnt = 0;
    end else begin
      mis = (m_count % 7) != m_res;
      if (mis) begin
        m_err = 1;
        m_cnt = clr ? 1 : (m_cnt == 255 ? 255 : m_cnt + 1);
      end else if (clr) begin
        m_err = 0; m_cnt = 0;
      end
      if (ld) begin
        m_count = lv; m_res = lv % 7;
      end else if (e && u) begin
        if (m_count >= lim) begin
          m_count = 0; m_res = 0; w = 1;
        end else begin
          m_count++; m_res = (m_res + 1) % 7;
        end
      end else if (e) begin
        if (m_count == 0) begin
          m_count = lim; m_res = lim % 7; w = 1;
        end else begin
          m_count--; m_res = (m_res + 6) % 7;
        end
      end
      if (f) m_count = m_count ^ 1;
    end
    x.count = m_count; x.wrap = w; x.res = m_res;
    x.err = m_err; x.cnt = m_cnt; x.id = n_cyc;
    q.push_back(x);
    n_cyc++;
  endtask

  task automatic hold(input int n, input bit clr);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 255, clr, 0);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("count", x.id, int'(count), x.count);
        chk("wrap", x.id, int'(wrap), x.wrap);
        chk("residue", x.id, int'(residue), x.res);
        chk("err", x.id, int'(err), x.err);
        chk("err_cnt", x.id, int'(err_cnt), x.cnt);
      end
    end
  end

  initial begin : stim
    int lim;
    n_chk = 0; n_fail = 0; n_cyc = 0;
    m_count = 0; m_res = 0; m_err = 0; m_cnt = 0;
    rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0;
    load_val = '0; limit = '0; err_clr = 1'b0; fault_inj = 1'b0;
    // Reset with noisy inputs must still clear everything.
    cyc(1, 1, 1, 1, 77, 9, 0, 1);
    // Count up to limit 9 and wrap.
    for (int i = 0; i < 12; i++) cyc(0, 1, 1, 0, 0, 9, 0, 0);
    // Down from 0 with full-range limit.
    cyc(0, 0, 0, 1, 0, 255, 0, 0);
    cyc(0, 1, 0, 0, 0, 255, 0, 0);
    cyc(0, 1, 0, 0, 0, 255, 0, 0);
    // Load beats enable.
    cyc(0, 1, 1, 1, 100, 255, 0, 0);
    // Lowered limit: up wraps, down decrements.
    cyc(0, 1, 1, 0, 0, 50, 0, 0);
    cyc(0, 1, 1, 1, 60, 50, 0, 0);
    cyc(0, 1, 0, 0, 0, 50, 0, 0);
    // Fault injection, sticky err, clear while mismatched.
    cyc(0, 0, 0, 1, 5, 255, 0, 0);
    cyc(0, 0, 0, 0, 0, 255, 0, 1);
    hold(3, 0);
    hold(3, 1);
    cyc(0, 0, 0, 1, 0, 255, 0, 0);
    hold(1, 1);
    hold(2, 0);
    // Saturation under persistent mismatch.
    cyc(0, 0, 0, 0, 0, 255, 0, 1);
    hold(300, 0);
    // Reset mid-count with err set.
    cyc(0, 0, 0, 1, 6, 255, 0, 1);
    hold(1, 0);
    cyc(1, 1, 1, 0, 0, 255, 0, 1);
    hold(1, 0);
    // Randomized traffic.
    lim = 20;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 63) == 0) lim = $urandom_range(0, 255);
      cyc($urandom_range(0, 49) == 0,
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 1) == 1,
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 255),
          lim,
          $urandom_range(0, 9) == 0,
          $urandom_range(0, 15) == 0);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
